// File: rtl/barrel_shift_pkg.sv
// Shared definitions for the barrel shifter family: shift-mode encoding and amount width.
package barrel_shift_pkg;
  localparam int SAMT_W = 5;

  typedef logic [1:0] shift_mode_t;

  localparam shift_mode_t SHIFT_LOGICAL = 2'b00;
  localparam shift_mode_t SHIFT_ARITH   = 2'b01;
  localparam shift_mode_t SHIFT_ROTATE  = 2'b10;
  localparam shift_mode_t SHIFT_RSVD    = 2'b11;
endpackage

// File: rtl/barrel_shift_right_stage.sv
// One conditional right shift by AMT bits; fill chosen by mode.
// Rotate fill exists only when BARREL_SHIFT_RIGHT_ROTATE_EN is defined.
module barrel_shift_right_stage
  import barrel_shift_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int AMT    = 1
) (
  input  logic [DATA_W-1:0] data,
  input  logic              enable,
  input  shift_mode_t       mode,
  input  logic              fill,
  output logic [DATA_W-1:0] q
);
  always_comb begin
    q = data;
    if (enable) begin
      case (mode)
        SHIFT_ARITH:  q = {{AMT{fill}}, data[DATA_W-1:AMT]};
`ifdef BARREL_SHIFT_RIGHT_ROTATE_EN
        SHIFT_ROTATE: q = {data[AMT-1:0], data[DATA_W-1:AMT]};
`endif
        default:      q = {{AMT{1'b0}}, data[DATA_W-1:AMT]};
      endcase
    end
  end
endmodule

// File: rtl/barrel_shift_right_pipe.sv
// Two-stage pipelined right barrel shifter (logical/arith, optional rotate via
// BARREL_SHIFT_RIGHT_ROTATE_EN) with a valid/ready handshake and a global stall.
module barrel_shift_right_pipe
  import barrel_shift_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] D_in,
  input  logic [SAMT_W-1:0] samt,
  input  shift_mode_t       mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] D_out,
  output logic [TAG_W-1:0]  out_tag
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [2:0]        samt_lo;
    shift_mode_t       mode;
    logic              sign;
    logic [TAG_W-1:0]  tag;
  } s1_t;

  logic [STAGES:1]         vld_pipe;
  s1_t                     s1, s1_nxt;
  logic [2:0][DATA_W-1:0]  c1;
  logic [3:0][DATA_W-1:0]  c2;
  logic                    stall;

  assign out_valid = vld_pipe[STAGES];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = rst_n && !stall;

  // Stage 1 combinational: shifts by 16 and 8, sign taken from the raw operand.
  assign c1[0] = D_in;
  for (genvar i = 0; i < 2; i++) begin : g_s1
    barrel_shift_right_stage #(.DATA_W(DATA_W), .AMT(16 >> i)) u_stage (
      .data   (c1[i]),
      .enable (samt[SAMT_W-1-i]),
      .mode   (mode),
      .fill   (D_in[DATA_W-1]),
      .q      (c1[i+1])
    );
  end

  assign s1_nxt = '{data: c1[2], samt_lo: samt[2:0], mode: mode,
                    sign: D_in[DATA_W-1], tag: in_tag};

  // Stage 2 combinational: shifts by 4, 2, 1 on the registered stage-1 data.
  assign c2[0] = s1.data;
  for (genvar i = 0; i < 3; i++) begin : g_s2
    barrel_shift_right_stage #(.DATA_W(DATA_W), .AMT(4 >> i)) u_stage (
      .data   (c2[i]),
      .enable (s1.samt_lo[2-i]),
      .mode   (s1.mode),
      .fill   (s1.sign),
      .q      (c2[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      D_out    <= '0;
      out_tag  <= '0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[STAGES-1], in_valid};
      s1       <= s1_nxt;
      D_out    <= c2[3];
      out_tag  <= s1.tag;
    end
  end
endmodule

// File: tb/tb_barrel_shift_right_pipe.sv
// Directed bench for barrel_shift_right_pipe: vector table plus stream, stall and reset sequences.
module tb_barrel_shift_right_pipe;
  import barrel_shift_pkg::*;

  localparam int DATA_W = 64;
  localparam int TAG_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] D_in;
  logic [4:0]        samt;
  shift_mode_t       mode;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] D_out;
  logic [TAG_W-1:0]  out_tag;

  int tests = 0;
  int fails = 0;

  barrel_shift_right_pipe #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .D_in(D_in), .samt(samt), .mode(mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .D_out(D_out), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [4:0]  s;
    shift_mode_t m;
    logic [3:0]  tag;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [4:0] s,
                       input shift_mode_t m, input logic [3:0] t);
    in_valid = v; D_in = d; samt = s; mode = m; in_tag = t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{64'h8000_0000_0000_0000, 5'd4,  SHIFT_LOGICAL, 4'h1, 64'h0800_0000_0000_0000};
    vecs[1]  = '{64'h8000_0000_0000_0000, 5'd31, SHIFT_ARITH,   4'h2, 64'hFFFF_FFFF_0000_0000};
    vecs[2]  = '{64'h4000_0000_0000_0000, 5'd1,  SHIFT_ARITH,   4'h3, 64'h2000_0000_0000_0000};
`ifdef BARREL_SHIFT_RIGHT_ROTATE_EN
    vecs[3]  = '{64'h0000_0000_0000_0001, 5'd1,  SHIFT_ROTATE,  4'h4, 64'h8000_0000_0000_0000};
    vecs[4]  = '{64'hF0F0_0000_0000_00FF, 5'd8,  SHIFT_ROTATE,  4'h5, 64'hFFF0_F000_0000_0000};
    vecs[5]  = '{64'h8000_0000_0000_0001, 5'd31, SHIFT_ROTATE,  4'h6, 64'h0000_0003_0000_0000};
`else
    vecs[3]  = '{64'h0000_0000_0000_0001, 5'd1,  SHIFT_ROTATE,  4'h4, 64'h0000_0000_0000_0000};
    vecs[4]  = '{64'hF0F0_0000_0000_00FF, 5'd8,  SHIFT_ROTATE,  4'h5, 64'h00F0_F000_0000_0000};
    vecs[5]  = '{64'h8000_0000_0000_0001, 5'd31, SHIFT_ROTATE,  4'h6, 64'h0000_0001_0000_0000};
`endif
    vecs[6]  = '{64'h0000_0000_0000_0001, 5'd1,  SHIFT_RSVD,    4'h7, 64'h0000_0000_0000_0000};
    vecs[7]  = '{64'hDEAD_BEEF_CAFE_F00D, 5'd0,  SHIFT_ARITH,   4'h8, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[8]  = '{64'hDEAD_BEEF_CAFE_F00D, 5'd0,  SHIFT_ROTATE,  4'h9, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[9]  = '{64'h8000_0000_0000_0001, 5'd16, SHIFT_ARITH,   4'hA, 64'hFFFF_8000_0000_0000};
    vecs[10] = '{64'h1234_5678_9ABC_DEF0, 5'd12, SHIFT_LOGICAL, 4'hB, 64'h0001_2345_6789_ABCD};
    vecs[11] = '{64'h7FFF_FFFF_FFFF_FFFF, 5'd31, SHIFT_ARITH,   4'hC, 64'h0000_0000_FFFF_FFFF};

    rst_n = 1'b0; out_ready = 1'b1;
    drive(1'b0, '0, '0, SHIFT_LOGICAL, '0);
    repeat (3) @(negedge clk);
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset D_out", D_out, 64'd0);
    chk("reset out_tag", {60'd0, out_tag}, 64'd0);
    chk("reset in_ready", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b1;

    // Single operands: latency of two edges, no early out_valid.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].d, vecs[i].s, vecs[i].m, vecs[i].tag);
      @(negedge clk);
      drive(1'b0, '0, '0, SHIFT_LOGICAL, '0);
      chk($sformatf("vec%0d early out_valid", i), {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      chk($sformatf("vec%0d out_valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("vec%0d D_out", i), D_out, vecs[i].exp);
      chk($sformatf("vec%0d out_tag", i), {60'd0, out_tag}, {60'd0, vecs[i].tag});
    end

    // Back-to-back stream of 8 operands at full rate.
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 9) begin
        chk($sformatf("stream%0d out_valid", c-2), {63'd0, out_valid}, 64'd1);
        chk($sformatf("stream%0d D_out", c-2), D_out, 64'h8000_0000_0000_0000 >> (c-2));
        chk($sformatf("stream%0d out_tag", c-2), {60'd0, out_tag}, 64'(c-2));
      end
      if (c == 10) chk("stream drained", {63'd0, out_valid}, 64'd0);
      chk($sformatf("stream%0d in_ready", c), {63'd0, in_ready}, 64'd1);
      if (c < 8) drive(1'b1, 64'h8000_0000_0000_0000, 5'(c), SHIFT_LOGICAL, 4'(c));
      else       drive(1'b0, '0, '0, SHIFT_LOGICAL, '0);
    end

    // Backpressure: A at output, B in stage 1, output held for 3 cycles.
    @(negedge clk);
    drive(1'b1, 64'hAAAA_0000_0000_0000, 5'd4, SHIFT_LOGICAL, 4'hA);
    @(negedge clk);
    drive(1'b1, 64'hBBBB_0000_0000_0000, 5'd8, SHIFT_LOGICAL, 4'hB);
    @(negedge clk);
    drive(1'b1, 64'hCCCC_CCCC_CCCC_CCCC, 5'd1, SHIFT_LOGICAL, 4'hC);
    out_ready = 1'b0;
    #1;
    chk("stall in_ready", {63'd0, in_ready}, 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d out_valid", c), {63'd0, out_valid}, 64'd1);
      chk($sformatf("stall%0d D_out", c), D_out, 64'h0AAA_A000_0000_0000);
      chk($sformatf("stall%0d out_tag", c), {60'd0, out_tag}, 64'hA);
      chk($sformatf("stall%0d in_ready", c), {63'd0, in_ready}, 64'd0);
    end
    drive(1'b0, '0, '0, SHIFT_LOGICAL, '0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("release B out_valid", {63'd0, out_valid}, 64'd1);
    chk("release B D_out", D_out, 64'h00BB_BB00_0000_0000);
    chk("release B out_tag", {60'd0, out_tag}, 64'hB);
    @(negedge clk);
    chk("release no dup", {63'd0, out_valid}, 64'd0);

    // Reset with two operands in flight, then accept on the first edge after release.
    drive(1'b1, 64'h1111_0000_0000_0000, 5'd0, SHIFT_LOGICAL, 4'h1);
    @(negedge clk);
    drive(1'b1, 64'h2222_0000_0000_0000, 5'd0, SHIFT_LOGICAL, 4'h2);
    @(negedge clk);
    drive(1'b0, '0, '0, SHIFT_LOGICAL, '0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst D_out", D_out, 64'd0);
    chk("midrst out_tag", {60'd0, out_tag}, 64'd0);
    chk("midrst in_ready", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b1;
    drive(1'b1, 64'h8000_0000_0000_0000, 5'd3, SHIFT_ARITH, 4'h5);
    @(negedge clk);
    drive(1'b0, '0, '0, SHIFT_LOGICAL, '0);
    chk("postrst no stale", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("postrst out_valid", {63'd0, out_valid}, 64'd1);
    chk("postrst D_out", D_out, 64'hF000_0000_0000_0000);
    chk("postrst out_tag", {60'd0, out_tag}, 64'h5);
    @(negedge clk);
    chk("postrst drained", {63'd0, out_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/barrel_shift_right_pipe.md
# barrel_shift_right_pipe

Pipelined 64-bit right barrel shifter, the right-direction counterpart to the team's combinational left shifter. Supports logical and arithmetic shift, and optionally rotate, by a 5-bit amount. It is split into two register stages behind a valid/ready handshake, so the datapath can feed it one operand per cycle and stall it without losing data.

## Interface
- DATA_W, 64, data width; must be ≥ 32; shift amount width is fixed at 5.
- TAG_W, 4, width of the opaque sideband tag carried alongside each operand.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand present.
- in_ready  out  1  block can accept this cycle.
- D_in  in  DATA_W  operand.
- samt  in  5  shift amount, 0..31.
- mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- D_out  out  DATA_W  shifted result.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Transfer on the input when in_valid && in_ready; on the output when out_valid && out_ready.
- Stage 1 register: applies samt[4] (16) and samt[3] (8) to D_in; captures the remaining samt[2:0], mode, tag and valid.
- Stage 2 register (the output): applies samt[2] (4), samt[1] (2) and samt[0] (1) to the stage-1 data.
- Fill rules per sub-shift by k bits:
  - logical: k zeros enter at the MSB.
  - arithmetic: k copies of the original D_in[DATA_W-1], carried in stage 1, enter at the MSB.
  - rotate: the k LSBs re-enter at the MSB.
- mode 11 behaves exactly as logical.
- samt = 0 passes D_in unchanged in every mode.
- Stall: stall = out_valid && !out_ready. While stalled, both stages hold data, tag and valid.
- in_ready = rst_n && !stall. This is a global stall: bubbles in stage 1 are not compressed.
- Stage 1 loads a bubble (valid 0) when not stalled and no input transfer occurs.
- Reset (any clk edge with rst_n = 0):
  - stage-1 valid and out_valid go to 0; D_out and out_tag go to 0; in_ready is 0.
  - In-flight operands are discarded, with no partial output.

## Timing
- Latency: an operand accepted at edge k shows out_valid = 1 with its result after edge k+2, provided the output is not stalled.
- Throughput: 1 operand per cycle while out_ready = 1.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from in_valid to out_valid.
- Simultaneous output transfer and input transfer in the same cycle is legal and sustains full rate.
- Release of reset: the first input can be accepted at the first edge with rst_n = 1.
- Results leave in acceptance order. The tag always accompanies its own operand.

## Configuration
- BARREL_SHIFT_RIGHT_ROTATE_EN
  - Defined: mode 10 rotates right as above.
  - Undefined: rotate logic is not built, and mode 10 behaves exactly as logical (zero fill).

## Structure
- Shared package barrel_shift_pkg holds:
  - mode encoding constants SHIFT_LOGICAL, SHIFT_ARITH, SHIFT_ROTATE, SHIFT_RSVD;
  - a typedef for the 2-bit mode field;
  - the constant SAMT_W = 5.
- Sub-module barrel_shift_right_stage: one conditional right shift by a parameter AMT, with inputs data, enable, mode and fill bit. It is instantiated five times: AMT = 16 and 8 in stage 1; 4, 2 and 1 in stage 2.

## Test plan
- Logical: D_in = 0x8000_0000_0000_0000, samt = 4, mode 00 → D_out = 0x0800_0000_0000_0000, two edges after acceptance.
- Arithmetic: same D_in, samt = 31, mode 01 → D_out = 0xFFFF_FFFF_0000_0000. D_in = 0x4000_0000_0000_0000, samt = 1, mode 01 → 0x2000_0000_0000_0000.
- Rotate: D_in = 0x0000_0000_0000_0001, samt = 1, mode 10 → 0x8000_0000_0000_0000 with the macro defined; 0x0 with it undefined. Mode 11 → 0x0.
- Back-to-back: 8 consecutive operands with samt = 0..7, tags 0..7, out_ready = 1 → 8 results on consecutive cycles, in order, tags matching.
- Backpressure: hold out_ready = 0 for 3 cycles with two operands in flight → in_ready = 0, D_out and out_tag stable, no loss or duplication; release → both delivered in order.
- Reset mid-operation: rst_n = 0 for one edge with two operands in flight → out_valid = 0, D_out = 0, out_tag = 0; no stale result appears after reset is released.
